// File: rtl/vec_pkg.sv
// Shared definitions for the ping-pong vector chunk buffer and its consumers.
//
// Contents:
//   DEF_VEC_LENGTH / DEF_WORKING_REGS : default geometry
//   chunk_t    : one chunk at the default width, lane WorkingRegs-1 is the MSB lane
//   bank_idx_t : selects one of the two banks
//   chunk_of() : chunk index of element k (arrival order)
//   lane_of()  : lane index of element k; the first element of a chunk goes
//                to the top lane so it lines up with the MVProd dot-product order
package vec_pkg;

  localparam int unsigned DEF_VEC_LENGTH   = 16;
  localparam int unsigned DEF_WORKING_REGS = 4;

  typedef logic signed [DEF_WORKING_REGS-1:0][7:0] chunk_t;
  typedef logic bank_idx_t;

  function automatic int unsigned chunk_of(input int unsigned k, input int unsigned wr);
    return k / wr;
  endfunction

  function automatic int unsigned lane_of(input int unsigned k, input int unsigned wr);
    return wr - 1 - (k % wr);
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One bank of the ping-pong vector buffer: NumChunks chunks of WorkingRegs
// signed bytes, held in flops.
//
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset (clears contents)
//   i_wr_en        : write one byte this cycle
//   i_wr_chunk     : chunk index of the byte being written
//   i_wr_lane      : lane index within that chunk
//   i_wr_data      : byte to write
//   i_rd_chunk     : chunk index to read
//   o_rd_data      : combinational read of chunk i_rd_chunk
module vec_bank #(
  parameter int unsigned VecLength   = 16,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned NumChunks   = VecLength / WorkingRegs,
  parameter int unsigned CW          = (NumChunks > 1) ? $clog2(NumChunks) : 1,
  parameter int unsigned LW          = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                i_wr_en,
  input  logic        [CW-1:0]                i_wr_chunk,
  input  logic        [LW-1:0]                i_wr_lane,
  input  logic signed [7:0]                   i_wr_data,
  input  logic        [CW-1:0]                i_rd_chunk,
  output logic signed [WorkingRegs-1:0][7:0]  o_rd_data
);

  logic signed [WorkingRegs-1:0][7:0] r_mem [NumChunks];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < NumChunks; c++) begin
        r_mem[c] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_chunk][i_wr_lane] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_chunk];

endmodule

// File: rtl/vec_chunk_buffer.sv
// Double-buffered vector store between two matrix-vector stages. One bank is
// filled byte by byte from the upstream result stream while the other is served
// as WorkingRegs-wide chunks to the downstream MVProd, which may re-read it any
// number of times (once per output row) before releasing it.
//
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset (discards all content)
//   wr_en, wr_data : byte stream in; accepted when wr_ready
//   wr_ready       : the current write bank is not full
//   rd_chunk_req   : advance the read pointer (wraps after the last chunk)
//   rd_ptr_rst     : rewind the read pointer to chunk 0
//   rd_release     : consumer is done with the current vector; free the bank
//   rd_data        : current chunk, combinational; zero when nothing is readable
//   rd_vec_ready   : the read bank holds a complete vector
//   vec_count      : number of full banks (0..2)
//   wr_overflow    : sticky, a write arrived while wr_ready was low
//   rd_underflow   : sticky, a chunk request arrived while rd_vec_ready was low
//
// Handshake: a write is consumed on a rising edge where wr_en && wr_ready;
// a chunk request/release is acted on only where rd_vec_ready is high, and
// release beats pointer rewind, which beats chunk request.
module vec_chunk_buffer
  import vec_pkg::*;
#(
  parameter int unsigned VecLength   = DEF_VEC_LENGTH,
  parameter int unsigned WorkingRegs = DEF_WORKING_REGS
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               wr_en,
  input  logic signed [7:0]                  wr_data,
  output logic                               wr_ready,
  input  logic                               rd_chunk_req,
  input  logic                               rd_ptr_rst,
  input  logic                               rd_release,
  output logic signed [WorkingRegs-1:0][7:0] rd_data,
  output logic                               rd_vec_ready,
  output logic [1:0]                         vec_count,
  output logic                               wr_overflow,
  output logic                               rd_underflow
);

  localparam int unsigned NumChunks = VecLength / WorkingRegs;
  localparam int unsigned CW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned LW = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;
  localparam int unsigned IW = (VecLength > 1) ? $clog2(VecLength) : 1;

  typedef logic signed [WorkingRegs-1:0][7:0] lchunk_t;

  bank_idx_t         r_wr_bank;
  bank_idx_t         r_rd_bank;
  logic [IW-1:0]     r_wr_idx;
  logic [CW-1:0]     r_rd_ptr;
  logic [1:0]        r_full;
  logic              r_wr_overflow;
  logic              r_rd_underflow;

  logic              w_wr_ready;
  logic              w_wr_accept;
  logic              w_wr_last;
  logic [CW-1:0]     w_wr_chunk;
  logic [LW-1:0]     w_wr_lane;
  logic              w_rd_ready;
  logic              w_release;
  logic              w_ptr_last;
  logic [1:0]        w_full_nxt;
  logic [1:0]        w_bank_we;
  lchunk_t           w_bank0_data;
  lchunk_t           w_bank1_data;

  // ---------------------------------------------------------------- write side
  assign w_wr_ready  = !r_full[r_wr_bank];
  assign w_wr_accept = wr_en && w_wr_ready;
  assign w_wr_last   = w_wr_accept && (r_wr_idx == IW'(VecLength - 1));
  assign w_wr_chunk  = CW'(chunk_of(int'(r_wr_idx), WorkingRegs));
  assign w_wr_lane   = LW'(lane_of(int'(r_wr_idx), WorkingRegs));
  assign w_bank_we[0] = w_wr_accept && (r_wr_bank == 1'b0);
  assign w_bank_we[1] = w_wr_accept && (r_wr_bank == 1'b1);

  // ----------------------------------------------------------------- read side
  assign w_rd_ready = r_full[r_rd_bank];
  assign w_release  = rd_release && w_rd_ready;
  assign w_ptr_last = (r_rd_ptr == CW'(NumChunks - 1));

  // Completion and release always target different banks (the read bank equals
  // the write bank only while that bank is empty), so both can apply together.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_bank      <= 1'b0;
      r_wr_idx       <= '0;
      r_full         <= '0;
      r_wr_overflow  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_accept) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (wr_en && !w_wr_ready) begin
        r_wr_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_bank      <= 1'b0;
      r_rd_ptr       <= '0;
      r_rd_underflow <= 1'b0;
    end else begin
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_ptr  <= '0;
      end else if (rd_ptr_rst) begin
        r_rd_ptr <= '0;
      end else if (rd_chunk_req && w_rd_ready) begin
        r_rd_ptr <= w_ptr_last ? '0 : r_rd_ptr + 1'b1;
      end
      if (rd_chunk_req && !w_rd_ready) begin
        r_rd_underflow <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- storage
  vec_bank #(
    .VecLength   (VecLength),
    .WorkingRegs (WorkingRegs)
  ) u_bank0 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_wr_en    (w_bank_we[0]),
    .i_wr_chunk (w_wr_chunk),
    .i_wr_lane  (w_wr_lane),
    .i_wr_data  (wr_data),
    .i_rd_chunk (r_rd_ptr),
    .o_rd_data  (w_bank0_data)
  );

  vec_bank #(
    .VecLength   (VecLength),
    .WorkingRegs (WorkingRegs)
  ) u_bank1 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_wr_en    (w_bank_we[1]),
    .i_wr_chunk (w_wr_chunk),
    .i_wr_lane  (w_wr_lane),
    .i_wr_data  (wr_data),
    .i_rd_chunk (r_rd_ptr),
    .o_rd_data  (w_bank1_data)
  );

  // ------------------------------------------------------------------- outputs
  assign wr_ready     = w_wr_ready;
  assign rd_vec_ready = w_rd_ready;
  assign rd_data      = !w_rd_ready ? '0 : (r_rd_bank ? w_bank1_data : w_bank0_data);
  assign vec_count    = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign wr_overflow  = r_wr_overflow;
  assign rd_underflow = r_rd_underflow;

endmodule

// File: tb/tb_vec_chunk_buffer.sv
module tb_vec_chunk_buffer;

  localparam int unsigned VL = 8;
  localparam int unsigned WR = 4;

  logic                      clk_in;
  logic                      rst_in;
  logic                      wr_en;
  logic signed [7:0]         wr_data;
  logic                      wr_ready;
  logic                      rd_chunk_req;
  logic                      rd_ptr_rst;
  logic                      rd_release;
  logic signed [WR-1:0][7:0] rd_data;
  logic                      rd_vec_ready;
  logic [1:0]                vec_count;
  logic                      wr_overflow;
  logic                      rd_underflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  vec_chunk_buffer #(
    .VecLength   (VL),
    .WorkingRegs (WR)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_chunk_req (rd_chunk_req),
    .rd_ptr_rst   (rd_ptr_rst),
    .rd_release   (rd_release),
    .rd_data      (rd_data),
    .rd_vec_ready (rd_vec_ready),
    .vec_count    (vec_count),
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_chunk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%h exp=<empty queue>", tag, rd_data);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, rd_data, e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check_eq({tag, "_vec_ready"}, 32'(rd_vec_ready), 32'd0);
    check_eq({tag, "_rd_data"}, rd_data, 32'd0);
    check_eq({tag, "_vec_count"}, 32'(vec_count), 32'd0);
    check_eq({tag, "_overflow"}, 32'(wr_overflow), 32'd0);
    check_eq({tag, "_underflow"}, 32'(rd_underflow), 32'd0);
  endtask

  // drivers: inputs change 1 time unit after a rising edge, outputs are
  // observed at that same point (well clear of the next edge)
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_req();
    rd_chunk_req = 1'b1;
    tick();
    rd_chunk_req = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic fill_seq(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      wr_byte(8'(first + i));
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    rd_chunk_req = 1'b0;
    rd_ptr_rst   = 1'b0;
    rd_release   = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    check_idle_outputs("reset");

    // 1: fill 1..8, read both chunks
    fill_seq(1, 7);
    check_eq("t1_not_ready_at_7", 32'(rd_vec_ready), 32'd0);
    wr_byte(8'd8);
    check_eq("t1_vec_ready", 32'(rd_vec_ready), 32'd1);
    check_eq("t1_vec_count", 32'(vec_count), 32'd1);
    check_eq("t1_wr_ready", 32'(wr_ready), 32'd1);
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h05060708);
    check_chunk("t1_chunk0");
    pulse_req();
    check_chunk("t1_chunk1");

    // 2: wrap and pointer rewind
    pulse_req();
    check_eq("t2_wrap", rd_data, 32'h01020304);
    pulse_req();
    pulse_req();
    check_eq("t2_wrap_twice", rd_data, 32'h01020304);
    pulse_req();
    check_eq("t2_before_rst", rd_data, 32'h05060708);
    rd_ptr_rst   = 1'b1;
    rd_chunk_req = 1'b1;
    tick();
    rd_ptr_rst   = 1'b0;
    rd_chunk_req = 1'b0;
    check_eq("t2_rst_priority", rd_data, 32'h01020304);

    // 3: release, then fill both banks and overflow
    pulse_release();
    check_eq("t3_empty_count", 32'(vec_count), 32'd0);
    check_eq("t3_empty_data", rd_data, 32'd0);
    fill_seq(1, 16);
    check_eq("t3_two_full", 32'(vec_count), 32'd2);
    check_eq("t3_wr_ready_low", 32'(wr_ready), 32'd0);
    check_eq("t3_first_vec", rd_data, 32'h01020304);
    wr_byte(8'd17);
    check_eq("t3_overflow", 32'(wr_overflow), 32'd1);
    check_eq("t3_count_after_ovf", 32'(vec_count), 32'd2);
    pulse_release();
    check_eq("t3_second_vec", rd_data, 32'h090a0b0c);
    check_eq("t3_count_after_rel", 32'(vec_count), 32'd1);
    check_eq("t3_wr_ready_back", 32'(wr_ready), 32'd1);
    pulse_req();
    check_eq("t3_second_chunk1", rd_data, 32'h0d0e0f10);

    // 4: underflow on an empty buffer, then signed fill
    pulse_release();
    check_eq("t4_empty", 32'(rd_vec_ready), 32'd0);
    pulse_req();
    check_eq("t4_underflow", 32'(rd_underflow), 32'd1);
    check_eq("t4_zero_data", rd_data, 32'd0);
    wr_byte(8'h80);
    wr_byte(8'hff);
    wr_byte(8'h00);
    wr_byte(8'h7f);
    fill_seq(5, 4);
    exp_q.push_back(32'h80ff007f);
    exp_q.push_back(32'h05060708);
    check_chunk("t4_chunk0");
    pulse_req();
    check_chunk("t4_chunk1");

    // 5: completion of one bank and release of the other on one edge
    fill_seq(8'h31, 7);
    check_eq("t5_count_pre", 32'(vec_count), 32'd1);
    wr_en      = 1'b1;
    wr_data    = 8'h38;
    rd_release = 1'b1;
    tick();
    wr_en      = 1'b0;
    rd_release = 1'b0;
    check_eq("t5_count_same", 32'(vec_count), 32'd1);
    check_eq("t5_vec_ready", 32'(rd_vec_ready), 32'd1);
    check_eq("t5_chunk0", rd_data, 32'h31323334);
    check_eq("t5_wr_ready", 32'(wr_ready), 32'd1);
    pulse_req();
    check_eq("t5_chunk1", rd_data, 32'h35363738);

    // 6: asynchronous reset mid-fill
    fill_seq(8'h51, 5);
    #2;
    rst_in = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    #1;
    rst_in = 1'b0;
    tick();
    fill_seq(8'h41, 7);
    check_eq("t6_no_partial", 32'(rd_vec_ready), 32'd0);
    wr_byte(8'h48);
    exp_q.push_back(32'h41424344);
    exp_q.push_back(32'h45464748);
    check_chunk("t6_chunk0");
    pulse_req();
    check_chunk("t6_chunk1");
    check_eq("t6_count", 32'(vec_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_chunk_buffer.md
Name: vec_chunk_buffer

Overview:
Double-buffered (ping-pong) vector store that sits between two matrix-vector stages. The write side accepts one signed byte per cycle, which is the serial result stream of the previous layer. The read side serves the same vector as WorkingRegs-wide chunks to the next MVProd, using that block's request/pointer-reset protocol. One bank fills while the other is read repeatedly, once per output row.

Parameters:
VecLength, 16, elements per vector; must be a multiple of WorkingRegs.
WorkingRegs, 4, bytes per chunk; must match the consuming MVProd.
NumChunks, VecLength/WorkingRegs (derived localparam), chunks per vector.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe; driven from upstream req_chunk_out
wr_data  input  signed [7:0]  element to store; driven from upstream write_out_data
wr_ready  output  1  write bank has space
rd_chunk_req  input  1  advance read pointer (consumer req_chunk_in)
rd_ptr_rst  input  1  rewind read pointer to chunk 0 (consumer req_chunk_ptr_rst)
rd_release  input  1  one-cycle pulse; consumer is finished with the current vector
rd_data  output  signed [WorkingRegs-1:0][7:0]  current chunk (consumer in_data)
rd_vec_ready  output  1  a complete vector is readable (consumer in_data_ready)
vec_count  output  2  number of full banks, 0..2
wr_overflow  output  1  sticky: a write was attempted while wr_ready=0
rd_underflow  output  1  sticky: a chunk request arrived while rd_vec_ready=0

Behaviour:
- Reset (async assert, sync release):
  - wr_bank=0, rd_bank=0, wr_idx=0, rd_ptr=0, full[1:0]=0.
  - Storage is cleared.
  - Outputs: wr_ready=1, rd_vec_ready=0, rd_data=0, vec_count=0, wr_overflow=0, rd_underflow=0.
  - Reset mid-fill or mid-read discards all content. No partial vector survives.
- Write:
  - Accepted when wr_en && wr_ready, where wr_ready = !full[wr_bank].
  - Element k (0-based, arrival order) is stored in chunk k/WorkingRegs, lane WorkingRegs-1-(k mod WorkingRegs). The first element of a chunk lands in the MSB lane, matching MVProd's dot-product lane order.
  - When write k=VecLength-1 is accepted: full[wr_bank] is set, wr_bank toggles and wr_idx returns to 0, all on the same edge.
  - wr_en while !wr_ready: data is dropped and wr_overflow is set (sticky until reset).
- Read:
  - rd_vec_ready = full[rd_bank].
  - rd_data is combinational: bank[rd_bank][rd_ptr] when rd_vec_ready, otherwise 0. Zero-latency, single-cycle FIFO semantics.
  - rd_chunk_req && rd_vec_ready: rd_ptr increments next edge and wraps from NumChunks-1 to 0.
  - rd_ptr_rst: rd_ptr becomes 0 next edge. It has priority over rd_chunk_req when both are asserted.
  - rd_chunk_req while !rd_vec_ready: rd_ptr is unchanged and rd_underflow is set (sticky).
  - rd_release && rd_vec_ready: full[rd_bank] clears, rd_bank toggles and rd_ptr becomes 0. rd_release has priority over rd_chunk_req and rd_ptr_rst.
  - rd_release while !rd_vec_ready is ignored.
- Latency:
  - Last element accepted on edge N: rd_vec_ready rises after edge N when that bank is rd_bank.
  - Release on edge N: the next full bank, if any, is presented after edge N.
  - A released bank is writable again after edge N (wr_ready high).
- Simultaneous events:
  - Write completion on one bank and release of the other on the same edge: both take effect and vec_count stays the same.
  - rd_bank==wr_bank implies that bank is not full, so release and write completion can never target the same full bank.
- vec_count = full[0]+full[1], updated on the same edges as the full flags.
- Storage: flops, 2*VecLength bytes. No RAM inference needed at these sizes.

Decomposition:
- Shared package vec_pkg:
  - chunk_t typedef (signed [WorkingRegs-1:0][7:0])
  - bank index type
  - lane-index function for element k, shared with MVProd benches
- One sub-module, vec_bank: a single bank holding NumChunks chunks, with lane-decoded byte write and combinational chunk read. The top instantiates two vec_bank instances and keeps the bank/full/pointer control itself.

Test Plan:
Bench parameters: VecLength=8, WorkingRegs=4.
1. Write 1..8 on consecutive cycles -> rd_vec_ready=1 the cycle after the 8th write. rd_data[3:0]={1,2,3,4} (lane3=1, lane0=4). After one rd_chunk_req, {5,6,7,8}.
2. Vector 1..8 ready; issue rd_chunk_req twice -> chunk 0 again (wrap). Issue rd_chunk_req then rd_ptr_rst together with rd_chunk_req -> {1,2,3,4}.
3. Write 16 bytes (1..16) -> vec_count=2, wr_ready=0. A 17th write sets wr_overflow=1 and vec_count stays 2. Pulse rd_release -> next cycle rd_data={9,10,11,12}, vec_count=1, wr_ready=1.
4. rd_chunk_req with an empty buffer -> rd_underflow=1, rd_data=0. A later fill still reads chunk 0 first.
5. One bank full and 7 bytes in the other; on the same edge, write the 8th byte and pulse rd_release -> vec_count stays 1 and the second vector is presented the next cycle.
6. Assert rst_in asynchronously (mid-cycle) after 5 writes -> outputs go to reset values immediately. A fresh 8-byte fill reads back only the new data.
